// File: rtl/sm83_mem_pkg.sv
// Shared definitions for the SM83 work-RAM subsystem: default widths,
// requester ids and arbiter priority states.
package sm83_mem_pkg;

  localparam int unsigned DefAddrW = 13;
  localparam int unsigned DefDataW = 8;

  typedef enum logic {
    ReqCpu = 1'b0,
    ReqVid = 1'b1
  } req_id_e;

  typedef enum logic {
    PrioVid = 1'b0,
    PrioCpu = 1'b1
  } prio_e;

endpackage

// File: rtl/sram_rd_pipe.sv
// Two-stage read-return tracker: carries the issuing port's id alongside the
// SRAM's one-cycle read latency and raises that port's valid strobe.
module sram_rd_pipe
  import sm83_mem_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    issue_i,
  input  req_id_e id_i,
  output logic    cpu_rvalid_o,
  output logic    vid_rvalid_o
);

  logic    s1_valid_q;
  req_id_e s1_id_q;
  logic    cpu_rvalid_q, cpu_rvalid_d;
  logic    vid_rvalid_q, vid_rvalid_d;

  always_comb begin
    cpu_rvalid_d = s1_valid_q && (s1_id_q == ReqCpu);
    vid_rvalid_d = s1_valid_q && (s1_id_q == ReqVid);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= ReqCpu;
      cpu_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
    end else begin
      s1_valid_q   <= issue_i;
      s1_id_q      <= id_i;
      cpu_rvalid_q <= cpu_rvalid_d;
      vid_rvalid_q <= vid_rvalid_d;
    end
  end

  assign cpu_rvalid_o = cpu_rvalid_q;
  assign vid_rvalid_o = vid_rvalid_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the single-port work SRAM: video has priority, but a
// streak counter hands the CPU one slot after VidBurstMax back-to-back video grants.
module sram_arbiter
  import sm83_mem_pkg::*;
#(
  parameter int unsigned AddrW       = sm83_mem_pkg::DefAddrW,
  parameter int unsigned DataW       = sm83_mem_pkg::DefDataW,
  parameter int unsigned VidBurstMax = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [AddrW-1:0] cpu_addr_i,
  input  logic [DataW-1:0] cpu_wdata_i,
  output logic             cpu_gnt_o,
  output logic             cpu_rvalid_o,
  output logic [DataW-1:0] cpu_rdata_o,
  input  logic             vid_req_i,
  input  logic             vid_we_i,
  input  logic [AddrW-1:0] vid_addr_i,
  input  logic [DataW-1:0] vid_wdata_i,
  output logic             vid_gnt_o,
  output logic             vid_rvalid_o,
  output logic [DataW-1:0] vid_rdata_o,
  output logic [AddrW-1:0] sram_address_o,
  output logic [DataW-1:0] sram_data_o,
  input  logic [DataW-1:0] sram_q_i,
  output logic             sram_wren_o
);

  localparam logic [3:0] StreakMax = 4'(VidBurstMax);

  prio_e            prio_q, prio_d;
  logic [3:0]       streak_q, streak_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] data_q, data_d;
  logic             wren_q, wren_d;
  logic             cpu_gnt, vid_gnt, cpu_xfer, vid_xfer, rd_issue;
  req_id_e          rd_id;

  // Grants see only REQs and the priority register; held low during reset.
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    if (rst_ni) begin
      if (prio_q == PrioCpu) begin
        cpu_gnt = cpu_req_i;
        vid_gnt = vid_req_i && !cpu_req_i;
      end else begin
        vid_gnt = vid_req_i;
        cpu_gnt = cpu_req_i && !vid_req_i;
      end
    end
  end

  assign cpu_xfer = cpu_req_i && cpu_gnt;
  assign vid_xfer = vid_req_i && vid_gnt;

  always_comb begin
    prio_d   = prio_q;
    streak_d = streak_q;
    if (cpu_xfer || !cpu_req_i) begin
      streak_d = 4'd0;
    end else if (vid_xfer) begin
      streak_d = streak_q + 4'd1;
      if (streak_d == StreakMax) begin
        prio_d = PrioCpu;
      end
    end
    if (cpu_xfer) begin
      prio_d = PrioVid;
    end
  end

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wren_d   = 1'b0;
    rd_issue = 1'b0;
    rd_id    = ReqCpu;
    if (vid_xfer) begin
      addr_d   = vid_addr_i;
      data_d   = vid_wdata_i;
      wren_d   = vid_we_i;
      rd_issue = !vid_we_i;
      rd_id    = ReqVid;
    end else if (cpu_xfer) begin
      addr_d   = cpu_addr_i;
      data_d   = cpu_wdata_i;
      wren_d   = cpu_we_i;
      rd_issue = !cpu_we_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q   <= PrioVid;
      streak_q <= 4'd0;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
    end
  end

  sram_rd_pipe u_rd_pipe (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .issue_i      (rd_issue),
    .id_i         (rd_id),
    .cpu_rvalid_o (cpu_rvalid_o),
    .vid_rvalid_o (vid_rvalid_o)
  );

  assign cpu_gnt_o      = cpu_gnt;
  assign vid_gnt_o      = vid_gnt;
  assign cpu_rdata_o    = sram_q_i;
  assign vid_rdata_o    = sram_q_i;
  assign sram_address_o = addr_q;
  assign sram_data_o    = data_q;
  assign sram_wren_o    = wren_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single-port 8 KiB work SRAM between two requesters, the SM83 CPU core and the video/DMA engine, behind one req/gnt handshake per port. It sits between the requesters and the SRAM macro and owns SRAM_ADDRESS, SRAM_DATA and SRAM_WREN. Video has fixed priority, bounded by a fairness counter so the CPU is never starved. Read data is returned to the issuing port with a valid strobe.

## Interface
- ADDR_W, 13, SRAM word-address width
- DATA_W, 8, data width
- VID_BURST_MAX, 4, maximum consecutive video grants while CPU_REQ is held (range 1..15)

- CLOCK  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- CPU_REQ  in  1  CPU access request; CPU_WE, CPU_ADDR and CPU_WDATA must be stable while CPU_REQ=1 and CPU_GNT=0
- CPU_WE  in  1  1=write, 0=read
- CPU_ADDR  in  ADDR_W  word address
- CPU_WDATA  in  DATA_W  write data
- CPU_GNT  out  1  combinational; transfer occurs at an edge where CPU_REQ&&CPU_GNT
- CPU_RVALID  out  1  registered; CPU_RDATA valid this cycle
- CPU_RDATA  out  DATA_W  read data
- VID_REQ, VID_WE, VID_ADDR, VID_WDATA, VID_GNT, VID_RVALID, VID_RDATA: same directions, widths and meaning for the video port
- SRAM_ADDRESS  out  ADDR_W  registered SRAM address
- SRAM_DATA  out  DATA_W  registered SRAM write data
- SRAM_Q  in  DATA_W  SRAM read data, valid one edge after the address is presented
- SRAM_WREN  out  1  registered write enable

## Operation
- Priority state: PRIO_VID (reset state) or PRIO_CPU. Counter vid_streak is 4 bits.
- In PRIO_VID: VID_GNT=VID_REQ and CPU_GNT=CPU_REQ&&!VID_REQ.
- In PRIO_CPU: CPU_GNT=CPU_REQ and VID_GNT=VID_REQ&&!CPU_REQ.
- At most one GNT is high in any cycle.
- vid_streak increments on each video transfer while CPU_REQ=1. It clears on any CPU transfer, or on any cycle with CPU_REQ=0.
- A video transfer that brings vid_streak to VID_BURST_MAX moves the state to PRIO_CPU.
- Any CPU transfer returns the state to PRIO_VID.
- On a transfer at edge k:
  - SRAM_ADDRESS, SRAM_DATA and SRAM_WREN load from the winning port.
  - If it is a read, the winner id and a valid bit enter a 2-stage pipeline.
- On a cycle with no transfer: SRAM_WREN=0, and SRAM_ADDRESS and SRAM_DATA hold their values.
- X_RDATA is driven from SRAM_Q for both ports. Only the RVALID of the issuing port is asserted.
- Writes produce no RVALID.
- Transfers complete in grant order. A read after a write to the same address returns the new data.

## Timing
- Throughput: one transfer per cycle, back-to-back from either port.
- Read latency: request accepted at edge k, SRAM_ADDRESS valid after k, SRAM_Q valid after k+1. X_RVALID is high between edges k+1 and k+2, so the requester samples the data at edge k+2.
- Write: SRAM_WREN is high for exactly the one cycle after edge k.
- GNT depends only on the REQs and the state register; there is no combinational path from SRAM_Q.
- Reset values (asynchronous, while RESET=0):
  - SRAM_ADDRESS=0, SRAM_DATA=0, SRAM_WREN=0
  - CPU_RVALID=0, VID_RVALID=0, CPU_RDATA/VID_RDATA don't-care
  - state=PRIO_VID, vid_streak=0
  - both GNT=0 regardless of REQ
- Reset mid-read: the pipeline is flushed and no RVALID is issued for the in-flight read.
- Simultaneous requests: video wins, except in PRIO_CPU.
- With VID_BURST_MAX=1, both requesters held continuously alternate strictly.
- A requester dropping REQ before its grant is legal; nothing is issued for it.

## Structure
- Shared package sm83_mem_pkg holds:
  - ADDR_W and DATA_W defaults
  - requester id constants REQ_CPU=1'b0, REQ_VID=1'b1
  - priority state encodings PRIO_VID=1'b0, PRIO_CPU=1'b1
- One sub-module, sram_rd_pipe: a 2-stage valid+id shift register with asynchronous clear, producing CPU_RVALID and VID_RVALID.
- Grant logic, fairness counter and SRAM output registers stay in the top module.

## Test plan
- CPU only: read 0x0010, SRAM preloaded with 0x3E -> CPU_GNT same cycle, CPU_RVALID for one cycle 2 edges later with CPU_RDATA=0x3E, VID_RVALID stays 0.
- VID write 0x1FFF=0xA5, then VID read 0x1FFF back-to-back -> SRAM_WREN high exactly 1 cycle, VID_RDATA=0xA5.
- Both REQ held continuously, VID_BURST_MAX=4 -> grant sequence V,V,V,V,C,V,V,V,V,C; never two GNTs in the same cycle.
- CPU_REQ drops after 2 video grants, then reasserts -> vid_streak clears, and the CPU waits a full 4 further video grants.
- RESET asserted one cycle after a CPU read is granted -> all outputs at reset values immediately, no CPU_RVALID after release, first post-reset grant goes to video when both request.
